// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder: buffers (A,B) operand pairs and streams each K_LEN-pair group through one MAC.
// Optional build macro MAC_FEED_PERF_EN adds o_perf_stalls (FEED cycles starved by an empty FIFO).
//
// state | meaning
// IDLE  | waiting for the first operand pair of a vector
// CLEAR | one-cycle mac_rst pulse, k restarts at 0
// FEED  | popping pairs into the MAC, stalls while the FIFO is empty
// WAIT  | letting the MAC pipeline settle, captures mac_out at the end
// HOLD  | result presented downstream until accepted
module mac_operand_feeder #(
    parameter int WIDTH      = 16,
    parameter int K_LEN      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MAC_LAT    = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_a,
    input  logic [WIDTH-1:0] i_in_b,
    output logic             o_mac_rst,
    output logic             o_mac_en,
    output logic [WIDTH-1:0] o_mac_a,
    output logic [WIDTH-1:0] o_mac_b,
    input  logic [WIDTH-1:0] i_mac_out,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [WIDTH-1:0] o_res_data
`ifdef MAC_FEED_PERF_EN
    ,
    output logic [15:0]      o_perf_stalls
`endif
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int KW = (K_LEN > 1) ? $clog2(K_LEN) : 1;
    localparam int LW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [KW-1:0] K_LAST    = KW'(K_LEN - 1);
    localparam logic [LW-1:0] LAT_LAST  = LW'(MAC_LAT - 1);
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_mem_a [FIFO_DEPTH];
    logic [WIDTH-1:0] r_mem_b [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [KW-1:0]    r_k;
    logic [LW-1:0]    r_lat;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_mac_en;

    // Operand FIFO: no empty bypass, a pushed pair is poppable the next cycle.
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == DEPTH_CNT);
    assign o_in_ready = !w_full && !i_rst;
    assign w_push     = i_in_valid && o_in_ready;
    assign w_pop      = w_mac_en;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= i_in_a;
            r_mem_b[r_wr_ptr] <= i_in_b;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_mac_en = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_next = S_FEED;
            end
            S_FEED: begin
                if (!w_empty) begin
                    w_mac_en = 1'b1;
                    if (r_k == K_LAST) begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_lat == LAT_LAST) begin
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (i_res_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        // Nothing reaches the MAC while reset is asserted, whatever state is still registered.
        if (i_rst) begin
            w_mac_en = 1'b0;
        end
    end

    assign o_mac_en  = w_mac_en;
    assign o_mac_a   = w_mac_en ? r_mem_a[r_rd_ptr] : '0;
    assign o_mac_b   = w_mac_en ? r_mem_b[r_rd_ptr] : '0;
    assign o_mac_rst = i_rst || (r_state == S_CLEAR);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_k         <= '0;
            r_lat       <= '0;
            o_res_valid <= 1'b0;
            o_res_data  <= '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_k <= '0;
                end
                S_FEED: begin
                    if (w_mac_en) begin
                        if (r_k == K_LAST) begin
                            r_k   <= '0;
                            r_lat <= '0;
                        end else begin
                            r_k <= r_k + KW'(1);
                        end
                    end
                end
                S_WAIT: begin
                    // mac_out is sampled exactly MAC_LAT cycles after the last enable.
                    if (r_lat == LAT_LAST) begin
                        o_res_data  <= i_mac_out;
                        o_res_valid <= 1'b1;
                    end else begin
                        r_lat <= r_lat + LW'(1);
                    end
                end
                S_HOLD: begin
                    if (i_res_ready) begin
                        o_res_valid <= 1'b0;
                    end
                end
                default: begin
                    r_k <= r_k;
                end
            endcase
        end
    end

`ifdef MAC_FEED_PERF_EN
    logic [15:0] r_perf_stalls;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_perf_stalls <= '0;
        end else if ((r_state == S_FEED) && w_empty && (r_perf_stalls != 16'hFFFF)) begin
            r_perf_stalls <= r_perf_stalls + 16'd1;
        end
    end

    assign o_perf_stalls = r_perf_stalls;
`endif

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Bench for mac_operand_feeder: two configurations share one stimulus stream and a MAC model,
// checked every cycle against a transaction-level model plus directed literal results.
module tb_mac_operand_feeder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic        res_ready = 1'b1;
    logic [15:0] in_a      = 16'd0;
    logic [15:0] in_b      = 16'd0;

    logic        rdy [2];
    logic        mrst [2];
    logic        men [2];
    logic        rv [2];
    logic [15:0] ma [2];
    logic [15:0] mb [2];
    logic [15:0] rdata [2];
    logic [15:0] mout0;
    logic [15:0] mout1;
`ifdef MAC_FEED_PERF_EN
    logic [15:0] perf [2];
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Instance 0: K_LEN=4, depth 4, MAC_LAT=1.  Instance 1: K_LEN=1, depth 2, MAC_LAT=3.
    function automatic int kof(input int i); return (i == 0) ? 4 : 1; endfunction
    function automatic int dof(input int i); return (i == 0) ? 4 : 2; endfunction
    function automatic int lof(input int i); return (i == 0) ? 1 : 3; endfunction

    mac_operand_feeder #(.WIDTH(16), .K_LEN(4), .FIFO_DEPTH(4), .MAC_LAT(1)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(rdy[0]),
        .i_in_a(in_a), .i_in_b(in_b), .o_mac_rst(mrst[0]), .o_mac_en(men[0]),
        .o_mac_a(ma[0]), .o_mac_b(mb[0]), .i_mac_out(mout0), .o_res_valid(rv[0]),
        .i_res_ready(res_ready), .o_res_data(rdata[0])
`ifdef MAC_FEED_PERF_EN
        , .o_perf_stalls(perf[0])
`endif
    );

    mac_operand_feeder #(.WIDTH(16), .K_LEN(1), .FIFO_DEPTH(2), .MAC_LAT(3)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(rdy[1]),
        .i_in_a(in_a), .i_in_b(in_b), .o_mac_rst(mrst[1]), .o_mac_en(men[1]),
        .o_mac_a(ma[1]), .o_mac_b(mb[1]), .i_mac_out(mout1), .o_res_valid(rv[1]),
        .i_res_ready(res_ready), .o_res_data(rdata[1])
`ifdef MAC_FEED_PERF_EN
        , .o_perf_stalls(perf[1])
`endif
    );

    // MAC cell model: rst clears, en accumulates A*B, out delayed to MAC_LAT cycles after en.
    logic [15:0] acc [2];
    logic [15:0] p0 [2];
    logic [15:0] p1 [2];
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mrst[i]) acc[i] <= 16'd0;
            else if (men[i]) acc[i] <= 16'(acc[i] + ma[i] * mb[i]);
            p0[i] <= acc[i];
            p1[i] <= p0[i];
        end
    end
    assign mout0 = acc[0];
    assign mout1 = p1[1];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h expected %0h at cycle %0d", nm, idx, act, exp, cyc);
        end
    endtask

    // Transaction-level reference: pair queue, vector progress, pending result with due cycle.
    logic [15:0] qa [2][16];
    logic [15:0] qb [2][16];
    int          hd [2];
    int          cnt [2];
    bit          act [2];
    bit          pend [2];
    int          kk [2];
    int          cst [2];
    int          fst [2];
    int          due [2];
    logic [15:0] accm [2];
    logic [15:0] rexp [2];
    int          perfm [2];
    bit          e_rdy, e_en, e_mrst, e_rv, idle_now;
    logic [15:0] e_a, e_b;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            e_rdy  = !rst && (cnt[i] < dof(i));
            e_en   = !rst && act[i] && (cyc >= fst[i]) && (cnt[i] > 0);
            e_a    = e_en ? qa[i][hd[i]] : 16'd0;
            e_b    = e_en ? qb[i][hd[i]] : 16'd0;
            e_mrst = rst || (act[i] && (cyc == cst[i]));
            e_rv   = pend[i] && (cyc >= due[i]);
            chk("in_ready", i, 32'(rdy[i]), 32'(e_rdy));
            chk("mac_en", i, 32'(men[i]), 32'(e_en));
            chk("mac_a", i, 32'(ma[i]), 32'(e_a));
            chk("mac_b", i, 32'(mb[i]), 32'(e_b));
            chk("mac_rst", i, 32'(mrst[i]), 32'(e_mrst));
            chk("res_valid", i, 32'(rv[i]), 32'(e_rv));
            if (e_rv) chk("res_data", i, 32'(rdata[i]), 32'(rexp[i]));
`ifdef MAC_FEED_PERF_EN
            chk("perf_stalls", i, 32'(perf[i]), 32'(perfm[i]));
`endif
            if (rst) begin
                hd[i] = 0; cnt[i] = 0; act[i] = 0; pend[i] = 0; kk[i] = 0; perfm[i] = 0;
            end else begin
                idle_now = !act[i] && !pend[i] && (cnt[i] > 0);
                if (act[i] && (cyc >= fst[i]) && (cnt[i] == 0) && (perfm[i] < 65535)) perfm[i]++;
                if (e_en) begin
                    accm[i] = 16'(accm[i] + qa[i][hd[i]] * qb[i][hd[i]]);
                    hd[i] = (hd[i] + 1) % 16;
                    cnt[i]--;
                    kk[i]++;
                    if (kk[i] == kof(i)) begin
                        act[i] = 0; pend[i] = 1; due[i] = cyc + lof(i) + 1; rexp[i] = accm[i];
                    end
                end
                if (e_rv && res_ready) pend[i] = 0;
                if (in_valid && e_rdy) begin
                    qa[i][(hd[i] + cnt[i]) % 16] = in_a;
                    qb[i][(hd[i] + cnt[i]) % 16] = in_b;
                    cnt[i]++;
                end
                if (idle_now) begin
                    act[i] = 1; cst[i] = cyc + 1; fst[i] = cyc + 2; kk[i] = 0; accm[i] = 16'd0;
                end
            end
        end
        cyc++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offers one pair until instance 0 accepts it.
    task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
        bit ok = 1'b0;
        in_valid = 1'b1; in_a = a; in_b = b;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = rdy[0];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL push_timeout got ready=0 expected ready=1 at cycle %0d", cyc);
        end
    endtask

    task automatic wait_result(input int idx, input logic [15:0] exp, input string nm);
        bit seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            seen = rv[idx];
            if (!seen) begin
                @(posedge clk);
                #1;
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s_timeout got no res_valid expected %0h at cycle %0d", nm, exp, cyc);
        end else begin
            chk(nm, idx, 32'(rdata[idx]), 32'(exp));
        end
        step(1);
    endtask

    initial begin
        // Reset behaviour.
        @(negedge clk);
        chk("rst_mac_rst", 0, 32'(mrst[0]), 32'd1);
        chk("rst_in_ready", 0, 32'(rdy[0]), 32'd0);
        chk("rst_res_valid", 0, 32'(rv[0]), 32'd0);
        chk("rst_mac_en", 0, 32'(men[0]), 32'd0);
        step(1);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 0, 32'(rdy[0]), 32'd1);
        chk("post_rst_mac_rst", 0, 32'(mrst[0]), 32'd0);
        chk("post_rst_res_data", 0, 32'(rdata[0]), 32'd0);
        step(1);

        // Back-to-back vector: 1*2+3*4+5*6+7*8 = 100.
        push_pair(16'd1, 16'd2); push_pair(16'd3, 16'd4);
        push_pair(16'd5, 16'd6); push_pair(16'd7, 16'd8);
        wait_result(0, 16'd100, "t2_result");
        step(10);

        // Backpressure: result 30 held, second vector (100) buffered until the handshake.
        res_ready = 1'b0;
        push_pair(16'd1, 16'd1); push_pair(16'd2, 16'd2);
        push_pair(16'd3, 16'd3); push_pair(16'd4, 16'd4);
        push_pair(16'd1, 16'd2); push_pair(16'd3, 16'd4);
        push_pair(16'd5, 16'd6); push_pair(16'd7, 16'd8);
        step(20);
        @(negedge clk);
        chk("t3_full_ready", 0, 32'(rdy[0]), 32'd0);
        chk("t3_held_valid", 0, 32'(rv[0]), 32'd1);
        chk("t3_held_data", 0, 32'(rdata[0]), 32'd30);
        step(1);
        res_ready = 1'b1;
        wait_result(0, 16'd30, "t3_first");
        wait_result(0, 16'd100, "t3_second");
        step(10);

        // Sparse input: stalls in FEED, same result.
        push_pair(16'd1, 16'd2); step(1);
        push_pair(16'd3, 16'd4); step(1);
        push_pair(16'd5, 16'd6); step(1);
        push_pair(16'd7, 16'd8); step(1);
        wait_result(0, 16'd100, "t4_result");
`ifdef MAC_FEED_PERF_EN
        chk("t4_perf_nonzero", 0, 32'(perf[0] != 16'd0), 32'd1);
`endif
        step(10);

        // Abort a partial vector with reset.
        push_pair(16'd5, 16'd5); push_pair(16'd6, 16'd6);
        step(6);
        @(negedge clk);
        chk("t5_no_result", 0, 32'(rv[0]), 32'd0);
        step(1);
        rst = 1'b1; step(1); rst = 1'b0;
        push_pair(16'd1, 16'd1); push_pair(16'd1, 16'd1);
        push_pair(16'd1, 16'd1); push_pair(16'd1, 16'd1);
        wait_result(0, 16'd4, "t5_result");
        step(10);

        // K_LEN=1, MAC_LAT=3 instance: 0x00FF * 2.
        push_pair(16'h00FF, 16'h0002);
        wait_result(1, 16'h01FE, "t6_result");
        step(10);

        // Randomized traffic with occasional reset.
        for (int n = 0; n < 1500; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = 16'($urandom);
            in_b      = 16'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 199) == 0);
            step(1);
        end
        rst = 1'b0; in_valid = 1'b0; res_ready = 1'b1;
        step(80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
